// File: rtl/fetch_controller_if.sv
// fetch_controller_if: control bundle between the fetch sequencer and the
// pipeline it steers.
//   master : sequencer side (samples hazard/branch/halt requests, drives
//            PC/IF-ID/ID-EX controls, status and event counters)
//   slave  : pipeline side (the mirror image)
interface fetch_controller_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   Imem_Ready;
  logic                   Load_Use_Stall;
  logic                   Branch_Taken;
  logic                   Halt_Req;
  logic                   Resume;
  logic                   PC_En;
  logic                   PC_Src;
  logic                   IF_ID_En;
  logic                   IF_ID_Flush;
  logic                   ID_EX_Flush;
  logic                   Fetch_Valid;
  logic                   Halted;
  logic [COUNT_WIDTH-1:0] Stall_Count;
  logic [COUNT_WIDTH-1:0] Flush_Count;

  modport master (
    input  Imem_Ready, Load_Use_Stall, Branch_Taken, Halt_Req, Resume,
    output PC_En, PC_Src, IF_ID_En, IF_ID_Flush, ID_EX_Flush, Fetch_Valid,
           Halted, Stall_Count, Flush_Count
  );

  modport slave (
    output Imem_Ready, Load_Use_Stall, Branch_Taken, Halt_Req, Resume,
    input  PC_En, PC_Src, IF_ID_En, IF_ID_Flush, ID_EX_Flush, Fetch_Valid,
           Halted, Stall_Count, Flush_Count
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: RV32i fetch-stage sequencer.
// Arbitrates branch redirects, load-use stalls, imem wait and halt/resume,
// and drives PC enable/select plus IF/ID and ID/EX enable/flush controls.
// Keeps saturating counters of stall cycles and accepted redirects.
//   CLK  : clock, all state on rising edge
//   RST  : synchronous active-high reset; outputs forced to reset values
//          combinationally while high
//   bus  : fetch_controller_if.master (requests in, controls/counters out)
module fetch_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                CLK,
  input  logic                RST,
  fetch_controller_if.master  bus
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {BOOT, RUN, DRAIN, HALTED} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [COUNT_WIDTH-1:0] stall_q, flush_q;

  logic pc_en, pc_src, ifid_en, ifid_flush, idex_flush, fetch_valid, halted;
  logic stall_inc, flush_inc;

  always_comb begin
    // Default is the "hold and bubble" shape shared by DRAIN/HALTED.
    state_d     = state_q;
    drain_d     = drain_q;
    pc_en       = 1'b0;
    pc_src      = 1'b0;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b1;
    idex_flush  = 1'b1;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      BOOT: begin
        ifid_en    = 1'b0;
        idex_flush = 1'b0;
        state_d    = RUN;
      end
      RUN: begin
        if (bus.Branch_Taken) begin
          // Redirect wins: any concurrent stall/halt is on the wrong path.
          pc_en     = 1'b1;
          pc_src    = 1'b1;
          flush_inc = 1'b1;
        end else if (bus.Load_Use_Stall) begin
          // Freeze PC and IF/ID, bubble into EX.
          ifid_en    = 1'b0;
          ifid_flush = 1'b0;
          stall_inc  = 1'b1;
        end else if (!bus.Imem_Ready) begin
          idex_flush = 1'b0;
          stall_inc  = 1'b1;
        end else if (bus.Halt_Req) begin
          // Halting instruction moves on to EX; PC stays at halt addr + 4.
          idex_flush = 1'b0;
          state_d    = DRAIN;
          drain_d    = DW'(DRAIN_CYCLES);
        end else begin
          pc_en       = 1'b1;
          ifid_flush  = 1'b0;
          idex_flush  = 1'b0;
          fetch_valid = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == DW'(1)) state_d = HALTED;
        else                   drain_d = drain_q - DW'(1);
      end
      HALTED: begin
        halted = 1'b1;
        if (bus.Resume) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase

    if (RST) begin
      state_d    = BOOT;
      pc_en      = 1'b0;
      pc_src     = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      fetch_valid = 1'b0;
      halted     = 1'b0;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BOOT;
      drain_q <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && stall_q != '1) stall_q <= stall_q + 1'b1;
      if (flush_inc && flush_q != '1) flush_q <= flush_q + 1'b1;
    end
  end

  assign bus.PC_En       = pc_en;
  assign bus.PC_Src      = pc_src;
  assign bus.IF_ID_En    = ifid_en;
  assign bus.IF_ID_Flush = ifid_flush;
  assign bus.ID_EX_Flush = idex_flush;
  assign bus.Fetch_Valid = fetch_valid;
  assign bus.Halted      = halted;
  // Counters read as zero for the whole reset window, not just after the edge.
  assign bus.Stall_Count = RST ? '0 : stall_q;
  assign bus.Flush_Count = RST ? '0 : flush_q;

endmodule

// File: tb/tb_fetch_controller.sv
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] target;
  logic [31:0] pc;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  fetch_controller_if #(.COUNT_WIDTH(32)) bus ();
  fetch_controller_if #(.COUNT_WIDTH(2))  bus2 ();

  fetch_controller #(.DRAIN_CYCLES(3), .COUNT_WIDTH(32)) dut (
    .CLK(clk), .RST(rst), .bus(bus.master));
  fetch_controller #(.DRAIN_CYCLES(3), .COUNT_WIDTH(2)) dut2 (
    .CLK(clk), .RST(rst), .bus(bus2.master));

  assign bus2.Imem_Ready     = bus.Imem_Ready;
  assign bus2.Load_Use_Stall = bus.Load_Use_Stall;
  assign bus2.Branch_Taken   = bus.Branch_Taken;
  assign bus2.Halt_Req       = bus.Halt_Req;
  assign bus2.Resume         = bus.Resume;

  // Fetch-stage PC register steered by the controller.
  always @(posedge clk)
    if (rst)             pc <= 32'h0;
    else if (bus.PC_En)  pc <= bus.PC_Src ? target : pc + 32'd4;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Phase of the core: booting, running, draining (with cycles left), halted.
  typedef enum {P_BOOT, P_RUN, P_DRAIN, P_HALTED} phase_t;
  phase_t m_phase = P_BOOT;
  int     m_left  = 0;
  longint m_stall = 0, m_flush = 0;

  function automatic longint sat(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  // {PC_En, PC_Src, IF_ID_En, IF_ID_Flush, ID_EX_Flush, Fetch_Valid, Halted}
  function automatic logic [6:0] expect_ctl();
    if (rst) return 7'b0001100;
    case (m_phase)
      P_BOOT:   return 7'b0001000;
      P_DRAIN:  return 7'b0011100;
      P_HALTED: return 7'b0011101;
      default: begin
        if (bus.Branch_Taken)        return 7'b1111100;
        else if (bus.Load_Use_Stall) return 7'b0000100;
        else if (!bus.Imem_Ready)    return 7'b0011000;
        else if (bus.Halt_Req)       return 7'b0011000;
        else                         return 7'b1010010;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    logic [6:0] e, a, m;
    e = expect_ctl();
    a = {bus.PC_En, bus.PC_Src, bus.IF_ID_En, bus.IF_ID_Flush,
         bus.ID_EX_Flush, bus.Fetch_Valid, bus.Halted};
    // PC_Src only matters when the PC actually loads.
    m = e[6] ? 7'h7F : 7'h3F;
    chk("ctl", a & m, e & m);
    chk("stall_cnt", bus.Stall_Count, rst ? 0 : sat(m_stall, 32));
    chk("flush_cnt", bus.Flush_Count, rst ? 0 : sat(m_flush, 32));
    chk("stall_cnt_w2", bus2.Stall_Count, rst ? 0 : sat(m_stall, 2));
    chk("flush_cnt_w2", bus2.Flush_Count, rst ? 0 : sat(m_flush, 2));
    // advance model to the state after the coming edge
    if (rst) begin
      m_phase = P_BOOT; m_stall = 0; m_flush = 0;
    end else begin
      case (m_phase)
        P_BOOT: m_phase = P_RUN;
        P_RUN: begin
          if (bus.Branch_Taken)        m_flush++;
          else if (bus.Load_Use_Stall) m_stall++;
          else if (!bus.Imem_Ready)    m_stall++;
          else if (bus.Halt_Req) begin m_phase = P_DRAIN; m_left = 3; end
        end
        P_DRAIN: begin
          m_left--;
          if (m_left == 0) m_phase = P_HALTED;
        end
        P_HALTED: if (bus.Resume) m_phase = P_RUN;
        default: ;
      endcase
    end
  end

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic quiet();
    bus.Branch_Taken = 0; bus.Load_Use_Stall = 0; bus.Halt_Req = 0;
    bus.Resume = 0; bus.Imem_Ready = 1;
  endtask

  initial begin
    rst = 1; target = 32'h0; quiet();
    // reset for two edges
    @(negedge clk);
    chk("rst_pc_en", bus.PC_En, 0);
    chk("rst_ifid_flush", bus.IF_ID_Flush, 1);
    chk("rst_idex_flush", bus.ID_EX_Flush, 1);
    nxt(); @(negedge clk); nxt();
    rst = 0;
    @(negedge clk);                         // BOOT
    chk("boot_pc_en", bus.PC_En, 0);
    chk("boot_idex_flush", bus.ID_EX_Flush, 0);
    chk("boot_pc", pc, 32'h0);
    nxt(); @(negedge clk);                  // first RUN
    chk("run_pc_en", bus.PC_En, 1);
    chk("run_pc0", pc, 32'h0);
    nxt(); @(negedge clk); chk("run_pc4", pc, 32'h4);
    nxt(); @(negedge clk); chk("run_pc8", pc, 32'h8);

    // redirect with concurrent stall
    nxt(); bus.Branch_Taken = 1; bus.Load_Use_Stall = 1; target = 32'h40;
    @(negedge clk);
    chk("br_pc_src", bus.PC_Src, 1);
    chk("br_pc_en", bus.PC_En, 1);
    chk("br_flushes", {bus.IF_ID_Flush, bus.ID_EX_Flush}, 2'b11);
    nxt(); quiet();
    @(negedge clk);
    chk("br_target", pc, 32'h40);
    chk("br_flush_cnt", bus.Flush_Count, 1);
    chk("br_stall_cnt", bus.Stall_Count, 0);

    // load-use stall for two cycles
    nxt(); bus.Load_Use_Stall = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lu_pc_en", bus.PC_En, 0);
      chk("lu_ifid_en", bus.IF_ID_En, 0);
      chk("lu_idex_flush", bus.ID_EX_Flush, 1);
      chk("lu_pc", pc, 32'h44);
      nxt();
    end
    quiet();
    @(negedge clk);
    chk("lu_stall_cnt", bus.Stall_Count, 2);
    chk("lu_pc_after", pc, 32'h44);

    // imem wait for three cycles
    nxt(); bus.Imem_Ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_fetch_valid", bus.Fetch_Valid, 0);
      chk("mw_ifid_flush", bus.IF_ID_Flush, 1);
      chk("mw_pc", pc, 32'h48);
      nxt();
    end
    quiet();
    @(negedge clk);
    chk("mw_stall_cnt", bus.Stall_Count, 5);
    chk("sat_stall_w2", bus2.Stall_Count, 3);
    chk("mw_pc_en", bus.PC_En, 1);
    nxt(); @(negedge clk); chk("mw_pc_resume", pc, 32'h4C);

    // halt with the halting instruction at 0x0C
    nxt(); bus.Branch_Taken = 1; target = 32'h0C;
    @(negedge clk); nxt(); quiet();
    @(negedge clk); chk("h_pc_c", pc, 32'h0C);
    nxt(); bus.Halt_Req = 1;
    @(negedge clk);
    chk("h_pc_10", pc, 32'h10);
    chk("h_pc_en", bus.PC_En, 0);
    nxt(); bus.Halt_Req = 0; bus.Branch_Taken = 1; target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_halted", bus.Halted, 0);
      chk("drain_pc_en", bus.PC_En, 0);
      chk("drain_pc", pc, 32'h10);
      nxt();
    end
    bus.Branch_Taken = 0;
    @(negedge clk);
    chk("halted", bus.Halted, 1);
    chk("halted_flush_cnt", bus.Flush_Count, 2);
    nxt(); bus.Resume = 1;
    @(negedge clk); chk("resume_cycle_halted", bus.Halted, 1);
    nxt(); bus.Resume = 0;
    @(negedge clk);
    chk("resumed_halted", bus.Halted, 0);
    chk("resumed_pc_en", bus.PC_En, 1);
    chk("resumed_pc", pc, 32'h10);
    nxt(); @(negedge clk); chk("resumed_pc_next", pc, 32'h14);

    // reset in the middle of DRAIN
    nxt(); bus.Halt_Req = 1;
    @(negedge clk); nxt(); bus.Halt_Req = 0;
    @(negedge clk); nxt(); rst = 1;
    @(negedge clk);
    chk("mrst_pc_en", bus.PC_En, 0);
    chk("mrst_flushes", {bus.IF_ID_Flush, bus.ID_EX_Flush}, 2'b11);
    chk("mrst_stall_cnt", bus.Stall_Count, 0);
    chk("mrst_halted", bus.Halted, 0);
    nxt(); rst = 0;
    @(negedge clk);
    chk("mrst_boot_idex", bus.ID_EX_Flush, 0);
    chk("mrst_boot_pc_en", bus.PC_En, 0);
    nxt(); @(negedge clk); chk("mrst_run_pc_en", bus.PC_En, 1);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      nxt();
      bus.Branch_Taken   = ($urandom_range(0, 99) < 12);
      bus.Load_Use_Stall = ($urandom_range(0, 99) < 15);
      bus.Imem_Ready     = ($urandom_range(0, 99) >= 15);
      bus.Halt_Req       = ($urandom_range(0, 99) < 6);
      bus.Resume         = ($urandom_range(0, 99) < 30);
      target             = {$urandom_range(0, 255), 2'b00};
      rst                = ($urandom_range(0, 199) < 2);
    end
    nxt(); rst = 0; quiet();
    @(negedge clk); nxt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
